// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: 32-step shift-add multiply and restoring divide.
// Operand B arrives one cycle after start and is captured in CAPB.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StCapb, StCalc, StDone} state_e;

  state_e               state_q;
  logic [1:0]           op_q;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     div_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic                 neg_q_q;
  logic                 neg_r_q;
  logic                 bzero_q;
  logic [CntW-1:0]      cnt_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 div_zero_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;

  logic                 signed_op;
  logic                 is_div;
  logic                 a_neg;
  logic                 b_neg;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH+1:0]     div_diff;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   acc_next;
  logic [2*WIDTH-1:0]   prod_res;
  logic [WIDTH-1:0]     quot_res;
  logic [WIDTH-1:0]     rem_res;
  logic [WIDTH-1:0]     res_hi;
  logic [WIDTH-1:0]     res_lo;

  // Magnitudes are taken in CAPB, when a_q is latched and op_b is valid.
  always_comb begin
    signed_op = ~op_q[0];
    is_div    = op_q[1];
    a_neg     = signed_op & a_q[WIDTH-1];
    b_neg     = signed_op & op_b[WIDTH-1];
    a_mag     = a_neg ? -a_q : a_q;
    b_mag     = b_neg ? -op_b : op_b;
  end

  // One iteration of each algorithm; acc holds {upper, lower} in both cases.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, div_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    div_diff = {1'b0, acc_q[2*WIDTH-1:WIDTH-1]} - {2'b00, div_q};
    if (div_diff[WIDTH+1]) begin
      div_next = {acc_q[2*WIDTH-2:0], 1'b0};
    end else begin
      div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end
    acc_next = is_div ? div_next : mul_next;
  end

  always_comb begin
    prod_res = neg_q_q ? -acc_next : acc_next;
    quot_res = neg_q_q ? -acc_next[WIDTH-1:0] : acc_next[WIDTH-1:0];
    rem_res  = neg_r_q ? -acc_next[2*WIDTH-1:WIDTH] : acc_next[2*WIDTH-1:WIDTH];
    res_hi   = prod_res[2*WIDTH-1:WIDTH];
    res_lo   = prod_res[WIDTH-1:0];
    if (is_div) begin
      if (bzero_q) begin
        res_hi = a_q;
        res_lo = '1;
      end else begin
        res_hi = rem_res;
        res_lo = quot_res;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      op_q       <= 2'b00;
      a_q        <= '0;
      div_q      <= '0;
      acc_q      <= '0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      bzero_q    <= 1'b0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (hi_we) hi_q <= wdata;
          if (lo_we) lo_q <= wdata;
          if (start) begin
            op_q    <= op;
            a_q     <= op_a;
            busy_q  <= 1'b1;
            state_q <= StCapb;
          end
        end
        StCapb: begin
          div_q   <= b_mag;
          acc_q   <= {{WIDTH{1'b0}}, a_mag};
          neg_q_q <= a_neg ^ b_neg;
          neg_r_q <= a_neg;
          bzero_q <= is_div & (op_b == '0);
          cnt_q   <= '0;
          state_q <= StCalc;
        end
        StCalc: begin
          acc_q <= acc_next;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntW'(WIDTH - 1)) begin
            hi_q       <= res_hi;
            lo_q       <= res_lo;
            done_q     <= 1'b1;
            div_zero_q <= bzero_q;
            state_q    <= StDone;
          end
        end
        StDone: begin
          done_q     <= 1'b0;
          div_zero_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: vector table plus hand-written corner sequences.
module tb_mult_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .op_a     (op_a),
    .op_b     (op_b),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_dz;
  } vec_t;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Start at the next edge; op_b = b0 in the start cycle, b1 in CAPB, garbage after.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b0,
                        input logic [31:0] b1, output int lat);
    op = o; op_a = a; op_b = b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op_a = ~a; op_b = b1; op = ~o;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (n == 1) op_b = ~b1;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  vec_t vecs[13];
  int   lat;
  int   ndone;

  initial begin
    vecs[0]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1]  = '{MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[2]  = '{DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1'b1};
    vecs[4]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[5]  = '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[6]  = '{MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
    vecs[7]  = '{DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    vecs[8]  = '{DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
    vecs[9]  = '{DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
    vecs[10] = '{MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
    vecs[11] = '{DIVU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0};
    vecs[12] = '{DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002, 1'b0};

    rst_n = 1'b0; start = 1'b0; op = 2'b00; op_a = '0; op_b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    #12;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_dz", {63'd0, div_zero}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // First vector starts on the first rising edge after reset release.
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].a ^ 32'h5A5A1234, vecs[i].b, lat);
      check($sformatf("v%0d_latency", i), 64'(lat), 64'd33);
      check($sformatf("v%0d_hi", i), {32'd0, hi}, {32'd0, vecs[i].exp_hi});
      check($sformatf("v%0d_lo", i), {32'd0, lo}, {32'd0, vecs[i].exp_lo});
      check($sformatf("v%0d_dz", i), {63'd0, div_zero}, {63'd0, vecs[i].exp_dz});
      check($sformatf("v%0d_busy_at_done", i), {63'd0, busy}, 64'd1);
      @(posedge clk); #1;
      check($sformatf("v%0d_done_width", i), {63'd0, done}, 64'd0);
      check($sformatf("v%0d_idle", i), {62'd0, busy, div_zero}, 64'd0);
    end

    // Second-cycle op_b is the divisor actually used.
    run_op(DIVU, 32'd9, 32'd5, 32'd3, lat);
    check("late_opb_latency", 64'(lat), 64'd33);
    check("late_opb_result", {hi, lo}, {32'd0, 32'd3});
    @(posedge clk); #1;

    // MTHI in IDLE; lo untouched.
    hi_we = 1'b1; wdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    hi_we = 1'b0;
    check("mthi", {hi, lo}, {32'hA5A5A5A5, 32'd3});
    lo_we = 1'b1; wdata = 32'h0000BEEF;
    @(posedge clk); #1;
    lo_we = 1'b0;
    check("mtlo", {hi, lo}, {32'hA5A5A5A5, 32'h0000BEEF});

    // Start plus MTHI on the same edge: write lands, result later overwrites.
    op = MULTU; op_a = 32'd6; start = 1'b1; hi_we = 1'b1; wdata = 32'h11112222;
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0; op_b = 32'd7;
    check("same_edge_write", {32'd0, hi}, {32'd0, 32'h11112222});
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = n;
        break;
      end
    end
    check("same_edge_latency", 64'(lat), 64'd33);
    check("same_edge_result", {hi, lo}, {32'd0, 32'd42});
    @(posedge clk); #1;

    // Start and MTHI during CALC are ignored.
    op = MULTU; op_a = 32'd3; op_b = 32'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op_b = 32'd5;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (n == 10) begin
        start = 1'b1; op = DIVU; op_a = 32'd100; op_b = 32'd9;
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEADBEEF;
      end else begin
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      end
      if (done) begin
        lat = n;
        break;
      end
    end
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    check("busy_ignore_latency", 64'(lat), 64'd33);
    check("busy_ignore_result", {hi, lo}, {32'd0, 32'd15});
    ndone = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("busy_ignore_no_second_done", 64'(ndone), 64'd0);
    check("busy_ignore_idle", {63'd0, busy}, 64'd0);

    // Reset in the middle of CALC aborts the operation.
    op = MULTU; op_a = 32'd1000; op_b = 32'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op_b = 32'd1000;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    #2;
    rst_n = 1'b1;
    ndone = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("abort_no_done", 64'(ndone), 64'd0);
    check("abort_hilo_held", {hi, lo}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
